// File: rtl/datapath_sequencer_pkg.sv
// Shared definitions for the datapath sequencer: opcodes, ALU function codes,
// bus-D select codes, FSM states and instruction field positions.
package datapath_sequencer_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_MOV = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_LD  = 4'h9;
    localparam logic [3:0] OP_ST  = 4'hA;
    localparam logic [3:0] OP_BRZ = 4'hB;
    localparam logic [3:0] OP_JMP = 4'hC;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [3:0] FS_PASS_A = 4'd0;
    localparam logic [3:0] FS_ADD    = 4'd1;
    localparam logic [3:0] FS_SUB    = 4'd2;
    localparam logic [3:0] FS_AND    = 4'd3;
    localparam logic [3:0] FS_OR     = 4'd4;
    localparam logic [3:0] FS_XOR    = 4'd5;
    localparam logic [3:0] FS_NOT_A  = 4'd6;
    localparam logic [3:0] FS_PASS_B = 4'd7;

    localparam logic [1:0] MD_ALU = 2'd0;
    localparam logic [1:0] MD_MEM = 2'd1;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int DR_MSB  = 11;
    localparam int DR_LSB  = 9;
    localparam int SA_MSB  = 8;
    localparam int SA_LSB  = 6;
    localparam int SB_MSB  = 5;
    localparam int SB_LSB  = 3;
    localparam int IMM_MSB = 2;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        CLS_NOP = 3'd0,
        CLS_ALU = 3'd1,
        CLS_LD  = 3'd2,
        CLS_ST  = 3'd3,
        CLS_BRZ = 3'd4,
        CLS_JMP = 3'd5,
        CLS_HLT = 3'd6
    } cls_e;

    typedef struct packed {
        logic [3:0] fs;
        logic       mb;
        logic [1:0] md;
        cls_e       cls;
        logic       ill;
    } dec_t;

    // Sign-extend a 3-bit branch offset to the program counter width.
    function automatic logic [7:0] sext_imm8(input logic [2:0] imm);
        return {{5{imm[2]}}, imm};
    endfunction

endpackage

// File: rtl/datapath_sequencer_decode.sv
// Combinational opcode decoder: ALU function, B-mux, bus-D select,
// sequencing class and illegal-opcode flag.
module seq_decode
    import datapath_sequencer_pkg::*;
(
    input  logic [3:0] op_i,
    output dec_t       dec_o
);

    // Opcode to control-field lookup.
    always_comb begin
        dec_o.fs  = FS_PASS_A;
        dec_o.mb  = 1'b0;
        dec_o.md  = MD_ALU;
        dec_o.cls = CLS_NOP;
        dec_o.ill = 1'b0;
        case (op_i)
            OP_NOP: dec_o.cls = CLS_NOP;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                dec_o.fs  = op_i;
                dec_o.cls = CLS_ALU;
            end
            OP_MOV: dec_o.cls = CLS_ALU;
            OP_LDI: begin
                dec_o.fs  = FS_PASS_B;
                dec_o.mb  = 1'b1;
                dec_o.cls = CLS_ALU;
            end
            OP_LD: begin
                dec_o.md  = MD_MEM;
                dec_o.cls = CLS_LD;
            end
            OP_ST:  dec_o.cls = CLS_ST;
            OP_BRZ: dec_o.cls = CLS_BRZ;
            OP_JMP: dec_o.cls = CLS_JMP;
            OP_HLT: dec_o.cls = CLS_HLT;
            default: begin
                dec_o.cls = CLS_NOP;
                dec_o.ill = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle control unit for the 8-bit register-file/ALU/data-memory datapath.
// Owns the program counter and sequences fetch, decode, execute and memory access.
module datapath_sequencer
    import datapath_sequencer_pkg::*;
#(
    parameter int              PC_W        = 8,
    parameter logic [PC_W-1:0] RST_PC      = '0,
    parameter int              ACK_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] pc,
    input  logic [15:0]     instr,
    input  logic            instr_valid,
    input  logic            zero,
    input  logic [7:0]      bus_A,
    output logic [2:0]      DA,
    output logic [2:0]      AA,
    output logic [2:0]      BA,
    output logic            MB,
    output logic [3:0]      FS,
    output logic [1:0]      MD,
    output logic            RW,
    output logic            mem_req,
    output logic            MW,
    input  logic            mem_ack,
    output logic            halted,
    output logic            illegal,
    output logic            bus_err
);

    localparam logic [15:0] ACK_TO = 16'(ACK_TIMEOUT);

    state_e          state_q, state_d;
    cls_e            cls_q, cls_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [2:0]      imm_q, imm_d;
    logic [2:0]      da_q, da_d, aa_q, aa_d, ba_q, ba_d;
    logic [3:0]      fs_q, fs_d;
    logic            mb_q, mb_d;
    logic [1:0]      md_q, md_d;
    logic            ill_q, ill_d;
    logic            rw_q, rw_d;
    logic            mem_req_q, mem_req_d;
    logic            mw_q, mw_d;
    logic [15:0]     wait_q, wait_d;
    logic            halted_q, halted_d;
    logic            illegal_q, illegal_d;
    logic            bus_err_q, bus_err_d;
    dec_t            dec_s;
    logic [PC_W-1:0] imm_ext_s;
    logic            ld_ack_s;

    seq_decode u_decode (
        .op_i  (instr[OP_MSB:OP_LSB]),
        .dec_o (dec_s)
    );

    assign imm_ext_s = {{(PC_W-3){imm_q[2]}}, imm_q};
    assign ld_ack_s  = (state_q == ST_MEM) && (cls_q == CLS_LD) && mem_ack;

    // Next-state and registered-output computation.
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        pc_d      = pc_q;
        imm_d     = imm_q;
        da_d      = da_q;
        aa_d      = aa_q;
        ba_d      = ba_q;
        fs_d      = fs_q;
        mb_d      = mb_q;
        md_d      = md_q;
        ill_d     = ill_q;
        rw_d      = 1'b0;
        mem_req_d = mem_req_q;
        mw_d      = mw_q;
        wait_d    = wait_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        case (state_q)
            ST_FETCH: begin
                if (instr_valid) begin
                    // Address and function fields are latched here so they are stable from DECODE on.
                    pc_d    = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
                    imm_d   = instr[IMM_MSB:IMM_LSB];
                    da_d    = instr[DR_MSB:DR_LSB];
                    aa_d    = instr[SA_MSB:SA_LSB];
                    ba_d    = instr[SB_MSB:SB_LSB];
                    fs_d    = dec_s.fs;
                    mb_d    = dec_s.mb;
                    md_d    = dec_s.md;
                    cls_d   = dec_s.cls;
                    ill_d   = dec_s.ill;
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                illegal_d = illegal_q | ill_q;
                case (cls_q)
                    CLS_ALU: begin
                        rw_d    = 1'b1;
                        state_d = ST_EXEC;
                    end
                    CLS_LD: begin
                        mem_req_d = 1'b1;
                        mw_d      = 1'b0;
                        wait_d    = 16'd0;
                        state_d   = ST_MEM;
                    end
                    CLS_ST: begin
                        mem_req_d = 1'b1;
                        mw_d      = 1'b1;
                        wait_d    = 16'd0;
                        state_d   = ST_MEM;
                    end
                    CLS_BRZ, CLS_JMP: state_d = ST_EXEC;
                    CLS_HLT: begin
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                // Branch offset is relative to the already-incremented pc.
                if ((cls_q == CLS_BRZ) && zero) begin
                    pc_d = pc_q + imm_ext_s;
                end else if (cls_q == CLS_JMP) begin
                    pc_d = PC_W'(bus_A);
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_MEM: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mw_d      = 1'b0;
                    state_d   = ST_FETCH;
                end else if ((ACK_TIMEOUT != 0) && (wait_q == ACK_TO)) begin
                    bus_err_d = 1'b1;
                    mem_req_d = 1'b0;
                    mw_d      = 1'b0;
                    state_d   = ST_FETCH;
                end else begin
                    wait_d  = wait_q + 16'd1;
                    state_d = ST_MEM;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: begin
                mem_req_d = 1'b0;
                mw_d      = 1'b0;
                state_d   = ST_FETCH;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            cls_q     <= CLS_NOP;
            pc_q      <= RST_PC;
            imm_q     <= 3'd0;
            da_q      <= 3'd0;
            aa_q      <= 3'd0;
            ba_q      <= 3'd0;
            fs_q      <= 4'd0;
            mb_q      <= 1'b0;
            md_q      <= 2'd0;
            ill_q     <= 1'b0;
            rw_q      <= 1'b0;
            mem_req_q <= 1'b0;
            mw_q      <= 1'b0;
            wait_q    <= 16'd0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            pc_q      <= pc_d;
            imm_q     <= imm_d;
            da_q      <= da_d;
            aa_q      <= aa_d;
            ba_q      <= ba_d;
            fs_q      <= fs_d;
            mb_q      <= mb_d;
            md_q      <= md_d;
            ill_q     <= ill_d;
            rw_q      <= rw_d;
            mem_req_q <= mem_req_d;
            mw_q      <= mw_d;
            wait_q    <= wait_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign pc      = pc_q;
    assign DA      = da_q;
    assign AA      = aa_q;
    assign BA      = ba_q;
    assign FS      = fs_q;
    assign MB      = mb_q;
    assign MD      = md_q;
    // LD writes back in the very cycle the data memory acknowledges.
    assign RW      = rw_q | ld_ack_s;
    assign mem_req = mem_req_q;
    assign MW      = mw_q;
    assign halted  = halted_q;
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed self-checking bench for datapath_sequencer.
module tb_datapath_sequencer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  pc;
    logic [15:0] instr;
    logic        instr_valid;
    logic        zero;
    logic [7:0]  bus_A;
    logic [2:0]  DA, AA, BA;
    logic        MB;
    logic [3:0]  FS;
    logic [1:0]  MD;
    logic        RW, mem_req, MW, mem_ack;
    logic        halted, illegal, bus_err;

    int tests = 0;
    int fails = 0;

    datapath_sequencer #(.PC_W(8), .RST_PC(8'h00), .ACK_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .instr(instr), .instr_valid(instr_valid),
        .zero(zero), .bus_A(bus_A), .DA(DA), .AA(AA), .BA(BA), .MB(MB), .FS(FS),
        .MD(MD), .RW(RW), .mem_req(mem_req), .MW(MW), .mem_ack(mem_ack),
        .halted(halted), .illegal(illegal), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present an instruction until it is captured (pc reaches exp_pc), then drop valid.
    task automatic issue(input logic [15:0] w, input logic [7:0] exp_pc);
        instr       = w;
        instr_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (pc === exp_pc) break;
        end
        instr_valid = 1'b0;
        check("fetch_pc", {24'd0, pc}, {24'd0, exp_pc});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"},  {24'd0, pc}, 32'h00);
        check({tag, "_str"}, {29'd0, RW, mem_req, MW}, 32'd0);
        check({tag, "_adr"}, {23'd0, DA, AA, BA}, 32'd0);
        check({tag, "_ctl"}, {25'd0, FS, MB, MD}, 32'd0);
        check({tag, "_flg"}, {29'd0, halted, illegal, bus_err}, 32'd0);
    endtask

    initial begin
        int n;
        int rw_cnt;
        rst_n = 1'b0; instr = 16'h0000; instr_valid = 1'b0;
        zero = 1'b0; bus_A = 8'h00; mem_ack = 1'b0;

        #12;
        check_reset_outputs("rst");
        @(negedge clk); rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("idle_pc", {24'd0, pc}, 32'h00);
        check("idle_str", {29'd0, RW, mem_req, MW}, 32'd0);

        // ADD r1,r2,r3
        issue(16'h1298, 8'h01);
        check("add_adr", {23'd0, DA, AA, BA}, {23'd0, 3'd1, 3'd2, 3'd3});
        check("add_ctl", {25'd0, FS, MB, MD}, {25'd0, 4'd1, 1'b0, 2'd0});
        check("add_rw_decode", {31'd0, RW}, 32'd0);
        @(posedge clk); #1;
        check("add_rw_exec", {31'd0, RW}, 32'd1);
        rw_cnt = 0;
        repeat (3) begin @(posedge clk); #1; if (RW) rw_cnt++; end
        check("add_rw_once", rw_cnt, 32'd0);

        // LD r4,[r1] with ack in the third MEM cycle
        issue(16'h9840, 8'h02);
        @(posedge clk); #1;
        check("ld_m1", {28'd0, mem_req, MW, RW, MB}, {28'd0, 4'b1000});
        check("ld_md", {30'd0, MD}, 32'd1);
        check("ld_adr", {26'd0, DA, AA}, {26'd0, 3'd4, 3'd1});
        @(posedge clk); #1;
        check("ld_m2", {29'd0, mem_req, MW, RW}, {29'd0, 3'b100});
        @(posedge clk); #1;
        mem_ack = 1'b1; #1;
        check("ld_ack", {29'd0, mem_req, MW, RW}, {29'd0, 3'b101});
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check("ld_done", {30'd0, mem_req, RW}, 32'd0);

        // Advance to pc 05, then BRZ -2 taken
        issue(16'h0000, 8'h03);
        issue(16'h0000, 8'h04);
        issue(16'h0000, 8'h05);
        zero = 1'b1;
        issue(16'hB006, 8'h06);
        check("brz_fs", {28'd0, FS}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("brz_taken_pc", {24'd0, pc}, 32'h04);
        issue(16'h0000, 8'h05);
        zero = 1'b0;
        issue(16'hB006, 8'h06);
        repeat (2) @(posedge clk);
        #1;
        check("brz_not_taken_pc", {24'd0, pc}, 32'h06);

        // JMP via bus_A
        bus_A = 8'h40;
        issue(16'hC000, 8'h07);
        repeat (2) @(posedge clk);
        #1;
        check("jmp_pc", {24'd0, pc}, 32'h40);

        // LDI r5,#5
        issue(16'h8A05, 8'h41);
        check("ldi_ctl", {22'd0, DA, FS, MB, MD}, {22'd0, 3'd5, 4'd7, 1'b1, 2'd0});
        @(posedge clk); #1;
        check("ldi_rw", {31'd0, RW}, 32'd1);

        // ST with no ack: timeout
        issue(16'hA018, 8'h42);
        check("st_ba", {29'd0, BA}, 32'd3);
        @(posedge clk); #1;
        check("st_m1", {29'd0, mem_req, MW, RW}, {29'd0, 3'b110});
        n = 0; rw_cnt = 0;
        while (n < 40 && bus_err !== 1'b1) begin
            @(posedge clk); #1;
            n++;
            if (RW) rw_cnt++;
        end
        check("st_bus_err", {31'd0, bus_err}, 32'd1);
        check("st_wait_cycles", n, 32'd16);
        check("st_after", {29'd0, mem_req, MW, RW}, 32'd0);
        check("st_no_rw", rw_cnt, 32'd0);
        issue(16'h0000, 8'h43);

        // Undefined opcode D
        check("illegal_before", {31'd0, illegal}, 32'd0);
        issue(16'hD000, 8'h44);
        @(posedge clk); #1;
        check("illegal_set", {31'd0, illegal}, 32'd1);
        issue(16'h0000, 8'h45);
        @(posedge clk); #1;
        check("illegal_sticky", {30'd0, illegal, bus_err}, 32'd3);

        // HLT freezes pc
        issue(16'hF000, 8'h46);
        @(posedge clk); #1;
        check("halted", {31'd0, halted}, 32'd1);
        instr = 16'h1298; instr_valid = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        instr_valid = 1'b0;
        check("halt_pc_frozen", {24'd0, pc}, 32'h46);
        check("halt_no_rw", {31'd0, RW}, 32'd0);

        // Asynchronous reset away from clock edge
        @(negedge clk); #2;
        rst_n = 1'b0; #1;
        check_reset_outputs("rst2");
        @(negedge clk); rst_n = 1'b1;

        // Reset in the middle of an LD
        issue(16'h9840, 8'h01);
        @(posedge clk); #1;
        check("ld2_req", {31'd0, mem_req}, 32'd1);
        #2;
        rst_n = 1'b0; #1;
        check_reset_outputs("rst3");
        @(negedge clk); rst_n = 1'b1;
        rw_cnt = 0;
        repeat (4) begin @(posedge clk); #1; if (RW || mem_req || MW) rw_cnt++; end
        check("rst3_no_glitch", rw_cnt, 32'd0);
        check("rst3_pc", {24'd0, pc}, 32'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
